prio_encoder4_2_q: RTL and testbench
====================================

// Module: prio_encoder4_2_q
// PURPOSE
//  Registered 4-to-2 priority encoder with event queueing; inverse of the team's 2-to-4 decoder.
//  Captures one-hot/multi-hot request pulses, holds them as pending, emits one binary index per
//  transfer over a valid/ready output. Sits between request sources and any consumer of a 2-bit code.
// PARAMETERS
//  N             4   number of request lines (fixed 4 in this revision)
//  W             2   code width, = $clog2(N)
//  PRIORITY_HIGH 1   1: highest set index wins; 0: lowest set index wins
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  req_in     in   N  request pulses, sampled every cycle, OR'd into pending
//  clear      in   1  synchronous flush of pending and output stage
//  out_code   out  W  encoded index of the granted request
//  out_valid  out  1  out_code holds a code
//  out_ready  in   1  consumer accepts; transfer = out_valid & out_ready
//  pending    out  N  pending request register (queued, not yet loaded into output stage)
//  dup_err    out  1  one-cycle pulse: a request was lost (arrived while already pending)
// BEHAVIOUR
//  - One clock domain; reset is asynchronous, active-high. On rst: pending=0, out_valid=0,
//    out_code=0, dup_err=0. Reset mid-operation discards all queued and in-flight codes.
//  - Output stage "free" = !out_valid | out_ready. When free and pending!=0: load out_code =
//    selected index (per PRIORITY_HIGH), out_valid<=1, clear that pending bit, same edge.
//    When free and pending==0: out_valid<=0, out_code holds last value.
//  - Next pending = (pending & ~load_mask) | req_in. A req_in bit equal to the bit being loaded
//    re-sets it (new event, no error).
//  - Latency: req_in high in cycle c -> pending set after edge c -> out_valid after edge c+1
//    (2 cycles) when the output stage is free and no higher-priority bit is pending.
//  - Back-pressure: out_valid & !out_ready -> out_code, out_valid stable; pending keeps
//    accumulating. No reordering of the held code by later higher-priority requests.
//  - Throughput: one code per cycle with out_ready=1 continuously.
//  - dup_err (registered): pulses after edge c if any req_in[i] & pending[i] & !load_mask[i]
//    in cycle c. The duplicate is merged (lost); no counter.
//  - clear has priority over req_in and load in the same cycle: pending<=0, out_valid<=0,
//    dup_err<=0; req_in that cycle is dropped.
//  - Request matching the code currently held in the output stage is queued normally (not dup).
// STRUCTURE
//  - Shared constants header (enc_defs.vh): N, W, PRIORITY_HIGH encodings; shared with decoder.
//  - One sub-module: prio_sel -- combinational find-first over N bits, outputs W-bit index,
//    N-bit one-hot load_mask and any flag; parameterised by PRIORITY_HIGH.
//  - Top: pending register, output-stage register, dup_err register, free/load logic.
// TESTING (PRIORITY_HIGH=1 unless noted)
//  1. rst, then req_in=4'b0100 one cycle, out_ready=1 -> out_valid=1, out_code=2'b10 two cycles
//     later for exactly one cycle; pending=0 afterwards.
//  2. req_in=4'b1011 one cycle, out_ready=1 -> out_code 3,1,0 on three consecutive cycles;
//     with PRIORITY_HIGH=0 -> 0,1,3.
//  3. out_ready=0; req_in=0001 then 1000 -> out_code=0 held; pending=1000; raise out_ready ->
//     code 0 transfers, then code 3 next cycle.
//  4. out_ready=0, out stage holds 0, pending=0010; req_in=0010 -> dup_err=1 for one cycle,
//     pending still 0010; req_in=0001 same time -> no dup (matches held code).
//  5. pending=1100, out_valid=1; assert clear with req_in=0001 -> next cycle pending=0,
//     out_valid=0, no code 0 ever emitted.
//  6. rst asserted asynchronously mid-burst (between edges) -> out_valid, pending, dup_err
//     drop to 0 immediately; after release, new req_in=0010 yields code 1 with 2-cycle latency.

Source files
------------

// File: rtl/prio_encoder4_2_q_pkg.sv
// Shared encoder/decoder constants: line count, code width and priority-direction encodings.
package prio_encoder4_2_q_pkg;
  localparam int ENC_N     = 4;
  localparam int ENC_W     = 2;
  localparam int PRIO_LOW  = 0;
  localparam int PRIO_HIGH = 1;
endpackage

// File: rtl/prio_encoder4_2_q_prio_sel.sv
// Combinational find-first: picks the highest or lowest set request bit and returns its index and one-hot mask.
import prio_encoder4_2_q_pkg::*;

module prio_encoder4_2_q_prio_sel #(
  parameter int N             = ENC_N,
  parameter int W             = ENC_W,
  parameter int PRIORITY_HIGH = PRIO_HIGH
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic [N-1:0] mask,
  output logic         any
);

  // Scan direction is chosen so the last hit written is the winning bit.
  always_comb begin
    idx  = '0;
    mask = '0;
    any  = |req;
    if (PRIORITY_HIGH == PRIO_HIGH) begin
      for (int i = 0; i < N; i++)
        if (req[i]) idx = W'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (req[i]) idx = W'(i);
    end
    if (any) mask[idx] = 1'b1;
  end

endmodule

// File: rtl/prio_encoder4_2_q.sv
// Registered 4-to-2 priority encoder: queues request pulses as pending bits and hands out one index per valid/ready transfer.
import prio_encoder4_2_q_pkg::*;

module prio_encoder4_2_q #(
  parameter int N             = ENC_N,
  parameter int W             = ENC_W,
  parameter int PRIORITY_HIGH = PRIO_HIGH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic         clear,
  output logic [W-1:0] out_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         dup_err
);

  logic [W-1:0] sel_idx;
  logic [N-1:0] sel_mask;
  logic         sel_any;
  logic         free;
  logic         load;
  logic [N-1:0] load_mask;

  prio_encoder4_2_q_prio_sel #(
    .N             (N),
    .W             (W),
    .PRIORITY_HIGH (PRIORITY_HIGH)
  ) u_sel (
    .req  (pending),
    .idx  (sel_idx),
    .mask (sel_mask),
    .any  (sel_any)
  );

  assign free      = !out_valid || out_ready;
  assign load      = free && sel_any;
  assign load_mask = load ? sel_mask : '0;

  // Stage boundary: pending queue and output register; a bit leaving pending this edge may be re-armed by req_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      dup_err   <= 1'b0;
    end else if (clear) begin
      pending   <= '0;
      out_valid <= 1'b0;
      dup_err   <= 1'b0;
    end else begin
      pending <= (pending & ~load_mask) | req_in;
      dup_err <= |(req_in & pending & ~load_mask);
      if (free) begin
        out_valid <= sel_any;
        if (sel_any) out_code <= sel_idx;
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder4_2_q.sv
// Scoreboard bench: stimulus pushes expected codes, negedge monitors pop them on every transfer.
module tb_prio_encoder4_2_q;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_in = '0;
  logic       clear = 1'b0;
  logic       out_ready = 1'b1;
  logic [1:0] out_code;
  logic       out_valid;
  logic [3:0] pending;
  logic       dup_err;

  logic [3:0] req_lo = '0;
  logic [1:0] code_lo;
  logic       valid_lo;
  logic [3:0] pending_lo;
  logic       dup_lo;

  int tests = 0;
  int fails = 0;
  int q_hi[$];
  int q_lo[$];

  always #5 clk = ~clk;

  prio_encoder4_2_q #(.N(4), .W(2), .PRIORITY_HIGH(1)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .clear(clear),
    .out_code(out_code), .out_valid(out_valid), .out_ready(out_ready),
    .pending(pending), .dup_err(dup_err)
  );

  prio_encoder4_2_q #(.N(4), .W(2), .PRIORITY_HIGH(0)) dut_lo (
    .clk(clk), .rst(rst), .req_in(req_lo), .clear(1'b0),
    .out_code(code_lo), .out_valid(valid_lo), .out_ready(1'b1),
    .pending(pending_lo), .dup_err(dup_lo)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q_hi.size() == 0) chk("hi unexpected transfer code", int'(out_code), -1);
      else chk("hi transfer code", int'(out_code), q_hi.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && valid_lo) begin
      if (q_lo.size() == 0) chk("lo unexpected transfer code", int'(code_lo), -1);
      else chk("lo transfer code", int'(code_lo), q_lo.pop_front());
    end
  end

  initial begin
    #2;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset pending", int'(pending), 0);
    chk("reset out_code", int'(out_code), 0);
    chk("reset dup_err", int'(dup_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: single request, two-cycle latency, one-cycle valid
    req_in = 4'b0100; q_hi.push_back(2);
    step(); req_in = '0;
    chk("t1 valid after 1 edge", int'(out_valid), 0);
    chk("t1 pending set", int'(pending), 4'b0100);
    step();
    chk("t1 valid after 2 edges", int'(out_valid), 1);
    chk("t1 code", int'(out_code), 2);
    step();
    chk("t1 valid drops", int'(out_valid), 0);
    chk("t1 pending empty", int'(pending), 0);

    // 2: multi-hot burst, both priority directions
    req_in = 4'b1011; req_lo = 4'b1011;
    q_hi.push_back(3); q_hi.push_back(1); q_hi.push_back(0);
    q_lo.push_back(0); q_lo.push_back(1); q_lo.push_back(3);
    step(); req_in = '0; req_lo = '0;
    repeat (4) step();
    chk("t2 pending empty", int'(pending), 0);
    chk("t2 valid idle", int'(out_valid), 0);

    // 3: back-pressure holds the code while a higher request queues
    out_ready = 1'b0;
    req_in = 4'b0001; q_hi.push_back(0); q_hi.push_back(3);
    step(); req_in = 4'b1000;
    step(); req_in = '0;
    chk("t3 held valid", int'(out_valid), 1);
    chk("t3 held code", int'(out_code), 0);
    chk("t3 pending", int'(pending), 4'b1000);
    step(); step();
    chk("t3 code stable", int'(out_code), 0);
    out_ready = 1'b1;
    step(); step(); step();
    chk("t3 drained", int'(out_valid), 0);

    // 4: duplicate detection vs request matching the held code
    out_ready = 1'b0;
    req_in = 4'b0001; q_hi.push_back(0);
    step(); req_in = 4'b0010;
    step();
    chk("t4 held code", int'(out_code), 0);
    chk("t4 pending", int'(pending), 4'b0010);
    req_in = 4'b0010;
    step();
    chk("t4 dup pulse", int'(dup_err), 1);
    chk("t4 pending after dup", int'(pending), 4'b0010);
    req_in = 4'b0001;
    step(); req_in = '0;
    chk("t4 no dup for held code", int'(dup_err), 0);
    chk("t4 pending queued", int'(pending), 4'b0011);
    q_hi.push_back(1); q_hi.push_back(0);
    out_ready = 1'b1;
    repeat (4) step();
    chk("t4 drained", int'(out_valid), 0);

    // 5: clear beats a same-cycle request and discards the held code
    out_ready = 1'b0;
    req_in = 4'b0010;
    step(); req_in = 4'b1100;
    step(); req_in = '0;
    chk("t5 pending", int'(pending), 4'b1100);
    chk("t5 valid", int'(out_valid), 1);
    clear = 1'b1; req_in = 4'b0001;
    step(); clear = 1'b0; req_in = '0;
    chk("t5 pending cleared", int'(pending), 0);
    chk("t5 valid cleared", int'(out_valid), 0);
    out_ready = 1'b1;
    repeat (3) step();
    chk("t5 still idle", int'(out_valid), 0);

    // 6: asynchronous reset mid-burst, then normal latency afterwards
    req_in = 4'b1111; q_hi.push_back(3);
    step(); req_in = '0;
    step();
    #6;
    rst = 1'b1;
    #1;
    chk("t6 async valid", int'(out_valid), 0);
    chk("t6 async pending", int'(pending), 0);
    chk("t6 async dup", int'(dup_err), 0);
    q_hi.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    req_in = 4'b0010; q_hi.push_back(1);
    step(); req_in = '0;
    chk("t6 valid after 1 edge", int'(out_valid), 0);
    step();
    chk("t6 valid after 2 edges", int'(out_valid), 1);
    chk("t6 code", int'(out_code), 1);
    step(); step();

    chk("hi queue drained", q_hi.size(), 0);
    chk("lo queue drained", q_lo.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
